pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_controller_if.sv | 38 +++
 rtl/load_use_detector.sv | 23 ++
 rtl/pipeline_hazard_controller.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDmemWait = 2'd1,
        StImemWait = 2'd2,
        StRedirect = 2'd3
    } state_e;

    localparam logic [2:0] MEM_READ_NONE = 3'd0;

    localparam int unsigned STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == STALL_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline status inputs and stage-control outputs of the hazard controller.
interface pipeline_hazard_controller_if;
    import pipeline_ctrl_pkg::*;

    logic                   IMEM_BUSY_WAIT;
    logic                   DMEM_BUSY_WAIT;
    logic [4:0]             ID_RS1;
    logic [4:0]             ID_RS2;
    logic                   ID_RS1_USED;
    logic                   ID_RS2_USED;
    logic [2:0]             EX_MEM_READ;
    logic [4:0]             EX_RD;
    logic                   BRANCH_TAKEN;
    logic                   PC_EN;
    logic                   IF_ID_EN;
    logic                   ID_EX_EN;
    logic                   EX_MEM_EN;
    logic                   MEM_WB_EN;
    logic                   IF_ID_FLUSH;
    logic                   ID_EX_FLUSH;
    logic [1:0]             STATE;
    logic [STALL_CNT_W-1:0] STALL_CYCLES;

    modport master (
        output IMEM_BUSY_WAIT, DMEM_BUSY_WAIT, ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
               EX_MEM_READ, EX_RD, BRANCH_TAKEN,
        input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
               STATE, STALL_CYCLES
    );

    modport slave (
        input  IMEM_BUSY_WAIT, DMEM_BUSY_WAIT, ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
               EX_MEM_READ, EX_RD, BRANCH_TAKEN,
        output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
               STATE, STALL_CYCLES
    );

endinterface

// File: rtl/load_use_detector.sv
// Flags an ID-stage read of a register that the load in EX has not yet produced.
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [2:0] ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_i);
        rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_i);
        hazard_o = (ex_mem_read_i != MEM_READ_NONE) && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for a 5-stage pipeline: memory waits, redirects and load-use bubbles.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RESET,
    pipeline_hazard_controller_if.slave  hz
);

    state_e                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   load_use;
    logic                   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                   if_id_flush, id_ex_flush;

    load_use_detector u_load_use_detector (
        .id_rs1_i      (hz.ID_RS1),
        .id_rs2_i      (hz.ID_RS2),
        .id_rs1_used_i (hz.ID_RS1_USED),
        .id_rs2_used_i (hz.ID_RS2_USED),
        .ex_mem_read_i (hz.EX_MEM_READ),
        .ex_rd_i       (hz.EX_RD),
        .hazard_o      (load_use)
    );

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = StRun;
        pend_d      = pend_q;

        if (!RESET) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            pend_d    = 1'b0;
        end else if (hz.DMEM_BUSY_WAIT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_d   = StDmemWait;
        end else if (state_q == StRedirect) begin
            pc_en       = 1'b0;
            id_ex_flush = 1'b1;
            if (hz.IMEM_BUSY_WAIT) begin
                if_id_en = 1'b0;
                state_d  = StRedirect;
            end else begin
                // The fetch that completes now is the stale wrong-path one.
                if_id_flush = 1'b1;
                pend_d      = 1'b0;
            end
        end else if (state_q == StDmemWait && pend_q) begin
            // Redirect was interrupted by a DMEM freeze; hold IF and resume it.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = StRedirect;
        end else if (hz.BRANCH_TAKEN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (hz.IMEM_BUSY_WAIT) begin
                if_id_en = 1'b0;
                pend_d   = 1'b1;
                state_d  = StRedirect;
            end
        end else if (hz.IMEM_BUSY_WAIT) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = StImemWait;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StRun;
            pend_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (!pc_en) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    assign hz.PC_EN        = pc_en;
    assign hz.IF_ID_EN     = if_id_en;
    assign hz.ID_EX_EN     = id_ex_en;
    assign hz.EX_MEM_EN    = ex_mem_en;
    assign hz.MEM_WB_EN    = mem_wb_en;
    assign hz.IF_ID_FLUSH  = if_id_flush;
    assign hz.ID_EX_FLUSH  = id_ex_flush;
    assign hz.STATE        = state_q;
    assign hz.STALL_CYCLES = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed table-driven bench for pipeline_hazard_controller plus multi-cycle corner sequences.
module tb_pipeline_hazard_controller;

    // Control vector order: PC, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID flush, ID_EX flush.
    localparam logic [6:0] C_OFF    = 7'b00000_00;
    localparam logic [6:0] C_NORM   = 7'b11111_00;
    localparam logic [6:0] C_STALL  = 7'b00111_01;
    localparam logic [6:0] C_BR     = 7'b11111_11;
    localparam logic [6:0] C_BR_IB  = 7'b10111_11;
    localparam logic [6:0] C_RD_END = 7'b01111_11;

    typedef struct {
        logic       imem;
        logic       dmem;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [2:0] mr;
        logic [4:0] rd;
        logic       br;
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        logic [15:0] exp_cnt;
    } vec_t;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_fail;
    vec_t vecs [13];

    pipeline_hazard_controller_if hz ();

    pipeline_hazard_controller dut (
        .CLK   (CLK),
        .RESET (RESET),
        .hz    (hz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] ctl();
        return {hz.PC_EN, hz.IF_ID_EN, hz.ID_EX_EN, hz.EX_MEM_EN, hz.MEM_WB_EN,
                hz.IF_ID_FLUSH, hz.ID_EX_FLUSH};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic imem, input logic dmem, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [2:0] mr, input logic [4:0] rd, input logic br);
        hz.IMEM_BUSY_WAIT = imem;
        hz.DMEM_BUSY_WAIT = dmem;
        hz.ID_RS1         = rs1;
        hz.ID_RS2         = rs2;
        hz.ID_RS1_USED    = u1;
        hz.ID_RS2_USED    = u2;
        hz.EX_MEM_READ    = mr;
        hz.EX_RD          = rd;
        hz.BRANCH_TAKEN   = br;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //                imem dmem rs1 rs2 u1 u2 mr rd br  ctl       st     cnt
        vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_NORM,  2'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 3'd3, 5'd4, 1'b0, C_NORM,  2'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 3'd3, 5'd0, 1'b0, C_NORM,  2'd0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 3'd0, 5'd4, 1'b0, C_NORM,  2'd0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 3'd3, 5'd4, 1'b0, C_STALL, 2'd0, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, C_NORM,  2'd0, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 3'd1, 5'd9, 1'b0, C_STALL, 2'd0, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 3'd1, 5'd9, 1'b1, C_BR,    2'd0, 16'd2};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_NORM,  2'd0, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_STALL, 2'd0, 16'd2};
        vecs[10] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_STALL, 2'd2, 16'd3};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_NORM,  2'd2, 16'd4};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, C_NORM,  2'd0, 16'd4};

        // Reset window: asserted at 1 ns, released at 6 ns.
        RESET = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        #1 RESET = 1'b0;
        #2;
        check("reset_ctl", ctl(), C_OFF);
        check("reset_state", hz.STATE, 2'd0);
        check("reset_cnt", hz.STALL_CYCLES, 16'd0);
        #3 RESET = 1'b1;
        #1;
        check("post_reset_ctl", ctl(), C_NORM);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].imem, vecs[i].dmem, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].mr, vecs[i].rd, vecs[i].br);
            #1;
            check($sformatf("row%0d_ctl", i), ctl(), vecs[i].exp_ctl);
            check($sformatf("row%0d_state", i), hz.STATE, vecs[i].exp_state);
            check($sformatf("row%0d_cnt", i), hz.STALL_CYCLES, vecs[i].exp_cnt);
            step();
        end

        // DMEM freeze with a branch waiting in EX.
        drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dmem%0d_ctl", i), ctl(), C_OFF);
            step();
            check($sformatf("dmem%0d_state", i), hz.STATE, 2'd1);
        end
        hz.DMEM_BUSY_WAIT = 1'b0;
        #1;
        check("dmem_exit_ctl", ctl(), C_BR);
        check("dmem_exit_cnt", hz.STALL_CYCLES, 16'd7);
        step();
        hz.BRANCH_TAKEN = 1'b0;
        #1;
        check("dmem_after_state", hz.STATE, 2'd0);
        check("dmem_after_ctl", ctl(), C_NORM);
        step();

        // Redirect while the fetch is outstanding; BRANCH_TAKEN left high must be ignored.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1);
        #1;
        check("redir_br_ctl", ctl(), C_BR_IB);
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("redir_wait%0d_state", i), hz.STATE, 2'd3);
            check($sformatf("redir_wait%0d_ctl", i), ctl(), C_STALL);
            step();
        end
        hz.IMEM_BUSY_WAIT = 1'b0;
        #1;
        check("redir_end_state", hz.STATE, 2'd3);
        check("redir_end_ctl", ctl(), C_RD_END);
        step();
        hz.BRANCH_TAKEN = 1'b0;
        #1;
        check("redir_run_state", hz.STATE, 2'd0);
        check("redir_run_ctl", ctl(), C_NORM);
        check("redir_run_cnt", hz.STALL_CYCLES, 16'd10);
        step();

        // Reset asserted while in REDIRECT.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1);
        step();
        check("rr_pre_state", hz.STATE, 2'd3);
        RESET = 1'b0;
        #1;
        check("rr_state", hz.STATE, 2'd0);
        check("rr_ctl", ctl(), C_OFF);
        check("rr_cnt", hz.STALL_CYCLES, 16'd0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);
        RESET = 1'b1;
        #1;
        check("rr_release_ctl", ctl(), C_NORM);
        step();
        #1;
        check("rr_next_ctl", ctl(), C_NORM);
        check("rr_next_state", hz.STATE, 2'd0);

        // Saturation: 70000 IMEM stall cycles in total.
        hz.IMEM_BUSY_WAIT = 1'b1;
        #1;
        check("sat_ctl", ctl(), C_STALL);
        for (int i = 0; i < 65534; i++) step();
        check("sat_fffe", hz.STALL_CYCLES, 16'hFFFE);
        step();
        check("sat_ffff", hz.STALL_CYCLES, 16'hFFFF);
        for (int i = 0; i < 4465; i++) step();
        check("sat_hold", hz.STALL_CYCLES, 16'hFFFF);
        check("sat_state", hz.STATE, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
